instr_fetch_buffer: RTL and testbench
=====================================

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 Parameter ADDR_W, default 64 (WORD): PC and memory address width.
REQ-002 Parameter INSTR_W, default 32 (INSTR_LEN): instruction width.
REQ-003 Parameter DEPTH, default 4: prefetch FIFO entries; legal range 2..16.
REQ-004 Parameter RESET_PC, default 0: first fetch address after reset; bits [1:0] are zero.
REQ-005 clk  in  1  the block's only clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 imem_req  out  1  fetch request to the instruction memory this cycle.
REQ-008 imem_addr  out  ADDR_W  fetch address; meaningful when imem_req=1.
REQ-009 imem_data  in  INSTR_W  instruction returned exactly one cycle after its request.
REQ-010 redirect_valid  in  1  branch/exception redirect strobe.
REQ-011 redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored and treated as 0.
REQ-012 out_valid  out  1  FIFO head holds a valid instruction.
REQ-013 out_ready  in  1  decode accepts the head this cycle.
REQ-014 out_instr  out  INSTR_W  head instruction.
REQ-015 out_pc  out  ADDR_W  PC of the head instruction.
REQ-016 count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-017 The block holds fetch_pc, a DEPTH-entry {pc,instr} FIFO, and a 1-bit inflight flag with its captured pc.
REQ-018 Issue condition: imem_req=1 when no redirect is active, and (count + inflight) < DEPTH or a pop occurs this cycle.
REQ-019 imem_addr shall equal fetch_pc combinationally; on issue, fetch_pc <= fetch_pc + 4, wrapping modulo 2^ADDR_W.
REQ-020 A request issued in cycle N sets inflight for cycle N+1; in N+1 imem_data and the captured pc are written to the FIFO tail unless killed.
REQ-021 Pop occurs when out_valid=1 and out_ready=1; out_valid = (count != 0); out_instr/out_pc show the head.
REQ-022 Simultaneous write and pop leaves count unchanged; the credit rule guarantees a write never occurs while full.
REQ-023 Throughput: with out_ready held at 1, one instruction per cycle is delivered in steady state.
REQ-024 Latency: a request issued in cycle N is visible on out_valid/out_instr in cycle N+2 when the FIFO was empty.
REQ-025 Redirect in cycle R: the FIFO is emptied, any inflight response arriving in R+1 is discarded, and fetch_pc <= {redirect_pc[ADDR_W-1:2],2'b00}.
REQ-026 Redirect timing: imem_req=0 in cycle R; the first request at the redirect target issues in R+1.
REQ-027 A handshake coinciding with a redirect counts as consumed by decode; the FIFO is still fully flushed.
REQ-028 Back-to-back redirects: the last one wins and no stale instruction is ever emitted.
REQ-029 out_pc of consecutive entries differs by exactly 4, except across a redirect.

Reset
REQ-030 While reset=1: fetch_pc=RESET_PC, count=0, inflight=0, out_valid=0, imem_req=0; out_instr/out_pc are don't-care.
REQ-031 In the first cycle with reset=0, imem_req=1 with imem_addr=RESET_PC.
REQ-032 Reset asserted mid-operation discards the FIFO contents and any inflight response, with no output in the following cycle.
REQ-033 Reset overrides redirect_valid and out_ready.

Verification
REQ-034 Reset release, out_ready=1, memory word at addr k = k -> imem_addr 0,4,8,...; out_pc 0,4,8 with out_instr equal to the PC, first out_valid 2 cycles after release.
REQ-035 out_ready=0 for 10 cycles (DEPTH=4) -> count saturates at 4, imem_req=0 once count+inflight=4, out_pc stays 0; then out_ready=1 -> out_pc 0,4,8,12,16 in 5 consecutive cycles.
REQ-036 Redirect to 0x103 while 3 entries are held and one is inflight -> count=0 next cycle, inflight data dropped, next out_pc=0x100, then 0x104.
REQ-037 Redirect_valid in 2 consecutive cycles (0x40, then 0x80) -> no instruction emitted from 0x40, first out_pc=0x80.
REQ-038 redirect_pc = 2^ADDR_W-4 -> out_pc sequence 0xFFFF_FFFF_FFFF_FFFC, then 0x0 (wrap-around).
REQ-039 reset pulsed for 1 cycle with count=3 -> out_valid=0 the next cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: sequential PC fetch with a one-cycle memory,
// a DEPTH-entry {pc,instr} prefetch FIFO and redirect/flush handling.
module instr_fetch_buffer #(
  parameter int unsigned        ADDR_W   = 64,
  parameter int unsigned        INSTR_W  = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        imem_req,
  output logic [ADDR_W-1:0]           imem_addr,
  input  logic [INSTR_W-1:0]          imem_data,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INSTR_W-1:0]          out_instr,
  output logic [ADDR_W-1:0]           out_pc,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Fetch state
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_inflight_pc;

  // FIFO state
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];

  // Combinational control
  logic               w_pop;
  logic               w_issue;
  logic               w_write;
  logic [CNT_W:0]     w_occupancy;
  logic [ADDR_W-1:0]  w_redirect_target;
  logic [PTR_W-1:0]   w_rd_ptr_nxt;
  logic [PTR_W-1:0]   w_wr_ptr_nxt;

  // Issue credit, pop/write strobes and pointer wrap
  always_comb begin
    w_pop             = !reset && (r_count != '0) && out_ready;
    w_occupancy       = (CNT_W+1)'(r_count) + (CNT_W+1)'(r_inflight);
    w_issue           = !reset && !redirect_valid &&
                        ((w_occupancy < (CNT_W+1)'(DEPTH)) || w_pop);
    // A response landing in a redirect cycle belongs to the old path
    w_write           = r_inflight && !redirect_valid;
    w_redirect_target = redirect_pc & ~ADDR_W'(3);
    w_rd_ptr_nxt      = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
    w_wr_ptr_nxt      = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  end

  assign imem_req  = w_issue;
  assign imem_addr = r_fetch_pc;
  assign out_valid = !reset && (r_count != '0);
  assign count     = reset ? '0 : r_count;
  assign out_instr = r_instr_mem[r_rd_ptr];
  assign out_pc    = r_pc_mem[r_rd_ptr];

  // Fetch PC, inflight tracking, FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(4);
      end
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_target;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        if (w_write) r_wr_ptr <= w_wr_ptr_nxt;
        if (w_pop)   r_rd_ptr <= w_rd_ptr_nxt;
        if (w_write && !w_pop)      r_count <= r_count + CNT_W'(1);
        else if (!w_write && w_pop) r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (!reset && w_write) begin
      r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
      r_instr_mem[r_wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Testbench for instr_fetch_buffer: directed scenarios plus a randomized run
// checked against a queue-based transaction model.
module tb_instr_fetch_buffer;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [2:0]  count;

  int          errors;
  int          checks;
  logic [31:0] key;

  instr_fetch_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: word at addr is addr[31:0]^key, returned one cycle after request;
  // junk is returned when there was no request.
  always @(posedge clk) imem_data <= imem_req ? (imem_addr[31:0] ^ key) : 32'($urandom);

  task automatic drive(input logic rst, input logic rv, input logic [63:0] rpc, input logic rdy);
    reset = rst; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Holds reset for two edges; caller drives the first non-reset cycle.
  task automatic apply_reset();
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 64'h1234, 1'b1);
      #1;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req k=%0d got=%b exp=0", k, imem_req); end checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid k=%0d got=%b exp=0", k, out_valid); end checks++;
      if (count !== 3'd0) begin errors++; $display("FAIL rst_count k=%0d got=%0d exp=0", k, count); end checks++;
      next_cycle();
    end
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    #1;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rel_req got=%b exp=1", imem_req); end checks++;
    if (imem_addr !== 64'h0) begin errors++; $display("FAIL rel_addr got=%0h exp=0", imem_addr); end checks++;
    next_cycle();
  endtask

  task automatic test_sequential();
    key = 32'h0;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      #1;
      if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req k=%0d got=%b exp=1", k, imem_req); end checks++;
      if (imem_addr !== 64'(4 * k)) begin errors++; $display("FAIL seq_addr k=%0d got=%0h exp=%0h", k, imem_addr, 4 * k); end checks++;
      if (out_valid !== (k >= 2)) begin errors++; $display("FAIL seq_valid k=%0d got=%b exp=%b", k, out_valid, k >= 2); end checks++;
      if (k >= 2) begin
        if (out_pc !== 64'(4 * (k - 2))) begin errors++; $display("FAIL seq_pc k=%0d got=%0h exp=%0h", k, out_pc, 4 * (k - 2)); end checks++;
        if (out_instr !== 32'(4 * (k - 2))) begin errors++; $display("FAIL seq_instr k=%0d got=%0h exp=%0h", k, out_instr, 4 * (k - 2)); end checks++;
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    int exp_cnt;
    key = 32'hCAFE_0000;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 64'h0, 1'b0);
      #1;
      exp_cnt = (k <= 1) ? 0 : ((k - 1 > 4) ? 4 : k - 1);
      if (count !== 3'(exp_cnt)) begin errors++; $display("FAIL bp_count k=%0d got=%0d exp=%0d", k, count, exp_cnt); end checks++;
      if (imem_req !== (k <= 3)) begin errors++; $display("FAIL bp_req k=%0d got=%b exp=%b", k, imem_req, k <= 3); end checks++;
      if (k >= 2) begin
        if (out_pc !== 64'h0) begin errors++; $display("FAIL bp_hold_pc k=%0d got=%0h exp=0", k, out_pc); end checks++;
      end
      next_cycle();
    end
    for (int j = 0; j < 5; j++) begin
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      #1;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid j=%0d got=%b exp=1", j, out_valid); end checks++;
      if (out_pc !== 64'(4 * j)) begin errors++; $display("FAIL bp_drain_pc j=%0d got=%0h exp=%0h", j, out_pc, 4 * j); end checks++;
      if (out_instr !== (32'(4 * j) ^ key)) begin errors++; $display("FAIL bp_drain_instr j=%0d got=%0h exp=%0h", j, out_instr, 32'(4 * j) ^ key); end checks++;
      next_cycle();
    end
  endtask

  task automatic test_redirect_flush();
    key = $urandom;
    apply_reset();
    for (int k = 0; k < 4; k++) begin drive(1'b0, 1'b0, 64'h0, 1'b0); next_cycle(); end
    drive(1'b0, 1'b1, 64'h103, 1'b0);
    #1;
    if (count !== 3'd3) begin errors++; $display("FAIL rf_pre_count got=%0d exp=3", count); end checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rf_req_r got=%b exp=0", imem_req); end checks++;
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    #1;
    if (count !== 3'd0) begin errors++; $display("FAIL rf_count got=%0d exp=0", count); end checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_valid1 got=%b exp=0", out_valid); end checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rf_req1 got=%b exp=1", imem_req); end checks++;
    if (imem_addr !== 64'h100) begin errors++; $display("FAIL rf_addr1 got=%0h exp=100", imem_addr); end checks++;
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    #1;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_valid2 got=%b exp=0", out_valid); end checks++;
    next_cycle();
    for (int j = 0; j < 2; j++) begin
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      #1;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL rf_out_valid j=%0d got=%b exp=1", j, out_valid); end checks++;
      if (out_pc !== 64'(64'h100 + 4 * j)) begin errors++; $display("FAIL rf_out_pc j=%0d got=%0h exp=%0h", j, out_pc, 64'h100 + 4 * j); end checks++;
      if (out_instr !== (32'(32'h100 + 4 * j) ^ key)) begin errors++; $display("FAIL rf_out_instr j=%0d got=%0h", j, out_instr); end checks++;
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    key = $urandom;
    apply_reset();
    for (int k = 0; k < 4; k++) begin drive(1'b0, 1'b0, 64'h0, 1'b1); next_cycle(); end
    drive(1'b0, 1'b1, 64'h40, 1'b1);
    #1;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_req0 got=%b exp=0", imem_req); end checks++;
    next_cycle();
    drive(1'b0, 1'b1, 64'h80, 1'b1);
    #1;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_req1 got=%b exp=0", imem_req); end checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid1 got=%b exp=0", out_valid); end checks++;
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    #1;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid2 got=%b exp=0", out_valid); end checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL b2b_req2 got=%b exp=1", imem_req); end checks++;
    if (imem_addr !== 64'h80) begin errors++; $display("FAIL b2b_addr2 got=%0h exp=80", imem_addr); end checks++;
    next_cycle();
    #1;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid3 got=%b exp=0", out_valid); end checks++;
    next_cycle();
    for (int j = 0; j < 2; j++) begin
      #1;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid j=%0d got=%b exp=1", j, out_valid); end checks++;
      if (out_pc !== 64'(64'h80 + 4 * j)) begin errors++; $display("FAIL b2b_out_pc j=%0d got=%0h exp=%0h", j, out_pc, 64'h80 + 4 * j); end checks++;
      next_cycle();
    end
  endtask

  task automatic test_wrap();
    key = $urandom;
    apply_reset();
    for (int k = 0; k < 2; k++) begin drive(1'b0, 1'b0, 64'h0, 1'b1); next_cycle(); end
    drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    #1;
    if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_addr0 got=%0h exp=fffffffffffffffc", imem_addr); end checks++;
    next_cycle();
    #1;
    if (imem_addr !== 64'h0) begin errors++; $display("FAIL wrap_addr1 got=%0h exp=0", imem_addr); end checks++;
    next_cycle();
    #1;
    if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 got=%0h exp=fffffffffffffffc", out_pc); end checks++;
    if (out_instr !== (32'hFFFF_FFFC ^ key)) begin errors++; $display("FAIL wrap_instr0 got=%0h exp=%0h", out_instr, 32'hFFFF_FFFC ^ key); end checks++;
    next_cycle();
    #1;
    if (out_valid !== 1'b1 || out_pc !== 64'h0) begin errors++; $display("FAIL wrap_pc1 got=%0h valid=%b exp=0", out_pc, out_valid); end checks++;
    if (out_instr !== key) begin errors++; $display("FAIL wrap_instr1 got=%0h exp=%0h", out_instr, key); end checks++;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    key = $urandom;
    apply_reset();
    for (int k = 0; k < 4; k++) begin drive(1'b0, 1'b0, 64'h0, 1'b0); next_cycle(); end
    drive(1'b1, 1'b1, 64'h500, 1'b1);
    #1;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req_rst got=%b exp=0", imem_req); end checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid_rst got=%b exp=0", out_valid); end checks++;
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b0);
    #1;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b exp=0", out_valid); end checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL rm_count got=%0d exp=0", count); end checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin errors++; $display("FAIL rm_restart req=%b addr=%0h exp=1/0", imem_req, imem_addr); end checks++;
    next_cycle();
    drive(1'b0, 1'b0, 64'h0, 1'b1);
    #1;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid2 got=%b exp=0", out_valid); end checks++;
    next_cycle();
    #1;
    if (out_valid !== 1'b1 || out_pc !== 64'h0) begin errors++; $display("FAIL rm_first valid=%b pc=%0h exp=1/0", out_valid, out_pc); end checks++;
    next_cycle();
  endtask

  // Random traffic against a transaction model: a queue of expected PCs,
  // one outstanding fetch, and the next sequential fetch address.
  task automatic test_random();
    logic [63:0] q[$];
    logic [63:0] m_pc;
    logic [63:0] m_infl_pc;
    logic [63:0] rpc;
    int          m_infl;
    int          r;
    logic        rst, rv, rdy, exp_valid, pop, exp_req;
    int          exp_cnt;
    key = $urandom;
    apply_reset();
    m_pc = 64'h0; m_infl = 0; m_infl_pc = 64'h0;
    for (int c = 0; c < 3000; c++) begin
      r   = $urandom_range(0, 99);
      rst = (r < 2);
      rv  = (r >= 2 && r < 8);
      rdy = ($urandom_range(0, 9) < 6);
      rpc = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rpc[63:8] = '1;
      drive(rst, rv, rpc, rdy);
      #1;
      exp_valid = !rst && (q.size() != 0);
      exp_cnt   = rst ? 0 : q.size();
      pop       = exp_valid && rdy;
      exp_req   = !rst && !rv && ((q.size() + m_infl < 4) || pop);
      if (out_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, exp_valid); end checks++;
      if (count !== 3'(exp_cnt)) begin errors++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, exp_cnt); end checks++;
      if (imem_req !== exp_req) begin errors++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, imem_req, exp_req); end checks++;
      if (exp_req) begin
        if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr c=%0d got=%0h exp=%0h", c, imem_addr, m_pc); end checks++;
      end
      if (exp_valid) begin
        if (out_pc !== q[0]) begin errors++; $display("FAIL rnd_pc c=%0d got=%0h exp=%0h", c, out_pc, q[0]); end checks++;
        if (out_instr !== (q[0][31:0] ^ key)) begin errors++; $display("FAIL rnd_instr c=%0d got=%0h exp=%0h", c, out_instr, q[0][31:0] ^ key); end checks++;
      end
      if (rst) begin
        q.delete(); m_infl = 0; m_pc = 64'h0;
      end else if (rv) begin
        q.delete(); m_infl = 0; m_pc = rpc & ~64'h3;
      end else begin
        if (pop) void'(q.pop_front());
        if (m_infl != 0) q.push_back(m_infl_pc);
        m_infl = exp_req ? 1 : 0;
        if (exp_req) begin m_infl_pc = m_pc; m_pc = m_pc + 64'h4; end
      end
      next_cycle();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    key    = 32'h0;
    drive(1'b1, 1'b0, 64'h0, 1'b0);
    next_cycle();
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_flush();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
